// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier with signed/unsigned operands.
// Multiplies magnitudes one multiplier bit per cycle, then applies the result sign.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state, next_state;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // The most-negative value negates to itself, which read as unsigned is the correct magnitude.
  always_comb begin
    mag_a = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN:  if (count == CW'(WIDTH)) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bits are consumed while count < WIDTH; the cycle at count == WIDTH only hands over to FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            count  <= '0;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        RUN: begin
          if (count < CW'(WIDTH)) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
          end
        end
        FIX: begin
          product <= neg ? (~acc + 1'b1) : acc;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier (WIDTH=4): vector table,
// hand-written corner sequences, random ops and an exhaustive sweep against an arithmetic model.
module tb_seq_shift_add_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           in_ready;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] product;
  logic           out_valid;
  logic           out_ready;
  logic           busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic           vmode;
    logic [2*W-1:0] vexp;
  } vec_t;

  vec_t vecs[11];

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_ready(in_ready),
    .signed_mode(signed_mode),
    .a(a),
    .b(b),
    .product(product),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: interpret operands as integers and take the low 2*W bits of the true product.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic m);
    int xi, yi, p;
    xi = int'(x);
    yi = int'(y);
    if (m && x[W-1]) xi = xi - (1 << W);
    if (m && y[W-1]) yi = yi - (1 << W);
    p = xi * yi;
    return p[2*W-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts edges after the accepting edge until out_valid is seen (bounded).
  task automatic waitResult(output int lat, output logic [2*W-1:0] prod);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    prod = product;
  endtask

  // Called at posedge+1 with the block idle; returns at posedge+1 once out_valid is seen.
  task automatic applyStimulus(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic m,
                               output int lat, output logic [2*W-1:0] prod);
    checkOutput("in_ready_before_start", 16'(in_ready), 16'd1);
    a = xa;
    b = xb;
    signed_mode = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitResult(lat, prod);
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("in_ready_after_release", 16'(in_ready), 16'd1);
    checkOutput("out_valid_after_release", 16'(out_valid), 16'd0);
  endtask

  initial begin
    int lat;
    int cycles;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] held;
    logic [W-1:0] ra, rb;
    logic rm;
    int d;

    vecs[0]  = '{4'hF, 4'hF, 1'b0, 8'hE1};
    vecs[1]  = '{4'h8, 4'h8, 1'b1, 8'h40};
    vecs[2]  = '{4'hD, 4'h5, 1'b1, 8'hF1};
    vecs[3]  = '{4'h0, 4'hD, 1'b1, 8'h00};
    vecs[4]  = '{4'hF, 4'h1, 1'b1, 8'hFF};
    vecs[5]  = '{4'h7, 4'h7, 1'b1, 8'h31};
    vecs[6]  = '{4'h8, 4'h7, 1'b1, 8'hC8};
    vecs[7]  = '{4'h8, 4'h8, 1'b0, 8'h40};
    vecs[8]  = '{4'hF, 4'hF, 1'b1, 8'h01};
    vecs[9]  = '{4'h0, 4'h0, 1'b0, 8'h00};
    vecs[10] = '{4'h7, 4'h8, 1'b1, 8'hC8};

    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b0;

    #12;
    checkOutput("reset_product", 16'(product), 16'd0);
    checkOutput("reset_out_valid", 16'(out_valid), 16'd0);
    checkOutput("reset_busy", 16'(busy), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_reset", 16'(in_ready), 16'd1);

    $display("[TB] vector table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].vmode, lat, prod);
      checkOutput($sformatf("vec%0d_product", i), 16'(prod), 16'(vecs[i].vexp));
      checkOutput($sformatf("vec%0d_latency", i), 16'(lat), 16'(W + 2));
      releaseResult();
    end

    $display("[TB] start and operand changes during RUN");
    a = 4'h6;
    b = 4'h7;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 4'hF;
    b = 4'h9;
    signed_mode = 1'b1;
    waitResult(lat, prod);
    start = 1'b0;
    checkOutput("run_interference_product", 16'(prod), 16'h2A);
    checkOutput("run_interference_latency", 16'(lat), 16'(W + 2));
    releaseResult();

    $display("[TB] backpressure in DONE");
    applyStimulus(4'h3, 4'h5, 1'b0, lat, prod);
    checkOutput("bp_product", 16'(prod), 16'h0F);
    held = prod;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      a = 4'(i);
      b = 4'(15 - i);
      signed_mode = i[0];
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_valid_c%0d", i), 16'(out_valid), 16'd1);
      checkOutput($sformatf("bp_hold_c%0d", i), 16'(product), 16'(held));
    end
    start = 1'b0;
    checkOutput("bp_busy", 16'(busy), 16'd1);
    releaseResult();
    checkOutput("bp_product_retained", 16'(product), 16'h0F);

    $display("[TB] reset during RUN");
    a = 4'hF;
    b = 4'hF;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrun_reset_product", 16'(product), 16'd0);
    checkOutput("midrun_reset_out_valid", 16'(out_valid), 16'd0);
    checkOutput("midrun_reset_busy", 16'(busy), 16'd0);
    @(negedge clk);
    a = 4'h3;
    b = 4'h4;
    signed_mode = 1'b0;
    start = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("first_edge_accept_busy", 16'(busy), 16'd1);
    waitResult(lat, prod);
    checkOutput("after_reset_product", 16'(prod), 16'h0C);
    checkOutput("after_reset_latency", 16'(lat), 16'(W + 2));
    releaseResult();

    $display("[TB] random operations");
    for (int i = 0; i < 30; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rm = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rm, lat, prod);
      checkOutput($sformatf("rand%0d_product a=%0h b=%0h m=%0d", i, ra, rb, rm),
                  16'(prod), 16'(ref_mul(ra, rb, rm)));
      checkOutput($sformatf("rand%0d_latency", i), 16'(lat), 16'(W + 2));
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        @(posedge clk);
        #1;
      end
      checkOutput($sformatf("rand%0d_still_valid", i), 16'(out_valid), 16'd1);
      releaseResult();
    end

    $display("[TB] exhaustive back-to-back");
    out_ready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          a = 4'(x);
          b = 4'(y);
          signed_mode = m[0];
          start = 1'b1;
          @(posedge clk);
          #1;
          start = 1'b0;
          waitResult(lat, prod);
          cycles = lat;
          for (int k = 0; k < 4; k++) begin
            if (in_ready) break;
            @(posedge clk);
            #1;
            cycles++;
          end
          checkOutput($sformatf("exh_product m=%0d a=%0h b=%0h", m, x, y),
                      16'(prod), 16'(ref_mul(4'(x), 4'(y), m[0])));
          checkOutput($sformatf("exh_cycles m=%0d a=%0h b=%0h", m, x, y),
                      16'(cycles), 16'(W + 3));
        end
      end
    end
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
